simon_show_sequencer: RTL and testbench

- Plays back the stored Simon colour sequence on the four LEDs during the game's SHOW phase.
- The game controller pulses start with the current level. The block then walks pattern memory entries 0..level-1.
- Each entry lights one LED for ON_CYCLES, then blanks the LEDs for OFF_CYCLES.
- A one-cycle done pulse tells the controller to advance to the compare phase.

---
 rtl/simon_show_sequencer_if.sv | 25 ++
 rtl/simon_show_sequencer.sv | 127 ++++++++++++
 tb/tb_simon_show_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/simon_show_sequencer_if.sv
// Controller/memory-side bundle for the Simon SHOW-phase sequencer.
// The slave modport is the sequencer; the master modport is the game controller plus pattern memory.
interface simon_show_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   level;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_data;
    logic [3:0]        led;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] show_idx;

    modport master (
        output start, abort, level, mem_data,
        input  mem_addr, led, busy, done, show_idx
    );

    modport slave (
        input  start, abort, level, mem_data,
        output mem_addr, led, busy, done, show_idx
    );
endinterface

// File: rtl/simon_show_sequencer.sv
// Simon SHOW phase: plays pattern entries 0..level-1 on one-hot LEDs.
// Each entry is shown as one FETCH cycle, then ON_CYCLES lit, then OFF_CYCLES blank.
module simon_show_sequencer #(
    parameter int MAX_LEN    = 16,
    parameter int ADDR_W     = 4,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic                  clk,
    input  logic                  resetn,
    simon_show_sequencer_if.slave bus
);
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]     ON_LOAD   = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]     OFF_LOAD  = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0]     TIMER_ONE = TW'(1);
    localparam logic [ADDR_W:0]   MAX_LEN_W = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ON,
        ST_OFF,
        ST_DONE
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] idx, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [1:0]        color_q, color_d;
    logic [TW-1:0]     timer, timer_d;
    logic [ADDR_W:0]   level_clamped;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            idx     <= '0;
            len_q   <= '0;
            color_q <= '0;
            timer   <= '0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            len_q   <= len_d;
            color_q <= color_d;
            timer   <= timer_d;
        end
    end

    always_comb begin
        state_d       = state;
        idx_d         = idx;
        len_d         = len_q;
        color_d       = color_q;
        timer_d       = timer;
        level_clamped = (bus.level > MAX_LEN_W) ? MAX_LEN_W : bus.level;

        // abort outranks every transition; in IDLE it only suppresses a coincident start
        if (bus.abort && state != ST_IDLE) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        len_d   = level_clamped;
                        idx_d   = '0;
                        state_d = (level_clamped == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    color_d = bus.mem_data;
                    timer_d = ON_LOAD;
                    state_d = ST_ON;
                end
                ST_ON: begin
                    if (timer == '0) begin
                        timer_d = OFF_LOAD;
                        state_d = ST_OFF;
                    end else begin
                        timer_d = timer - TIMER_ONE;
                    end
                end
                ST_OFF: begin
                    if (timer == '0) begin
                        if ({1'b0, idx} == len_q - LEN_ONE) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx + IDX_ONE;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        timer_d = timer - TIMER_ONE;
                    end
                end
                ST_DONE: begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.led  = '0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            ST_FETCH: bus.busy = 1'b1;
            ST_ON: begin
                bus.busy = 1'b1;
                bus.led  = 4'b0001 << color_q;
            end
            ST_OFF:  bus.busy = 1'b1;
            ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_addr = idx;
    assign bus.show_idx = idx;
endmodule

// File: tb/tb_simon_show_sequencer.sv
// Scoreboard bench: a timeline model queues expected LED flashes and done pulses; a monitor pops them.
module tb_simon_show_sequencer;
    localparam int MAX_LEN = 16;
    localparam int ADDR_W  = 4;
    localparam int ON_C    = 4;
    localparam int OFF_C   = 2;
    localparam int PER     = 1 + ON_C + OFF_C;

    typedef struct {
        bit is_done;
        int cyc;
        int len;
        int color;
        int addr;
    } ev_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [1:0] mem_q [MAX_LEN];

    simon_show_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    simon_show_sequencer #(
        .MAX_LEN   (MAX_LEN),
        .ADDR_W    (ADDR_W),
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always_comb bus.mem_data = mem_q[bus.mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t q[$];
    int  exp_lo    = 1;
    int  exp_hi    = 0;
    int  last_done = -1;
    bit  mon_en    = 1'b0;

    int run_len = 0;
    int run_led, run_on, run_addr, run_sidx;

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, want);
        end
    endtask

    // Schedule of a whole playback from the start cycle: entry k lit from s+2+k*PER for ON_C cycles.
    task automatic model_start(input int s, input int lv);
        int  n;
        ev_t e;
        if (s <= last_done) return;
        n = (lv > MAX_LEN) ? MAX_LEN : lv;
        for (int k = 0; k < n; k++) begin
            e.is_done = 1'b0; e.cyc = s + 2 + k * PER; e.len = ON_C;
            e.color = int'(mem_q[k]); e.addr = k;
            q.push_back(e);
        end
        e.is_done = 1'b1; e.cyc = s + n * PER + 1; e.len = 0; e.color = 0; e.addr = 0;
        q.push_back(e);
        exp_lo    = s + 1;
        exp_hi    = s + n * PER;
        last_done = s + n * PER + 1;
    endtask

    // Cancel at cycle a: nothing after a survives, a flash in progress is cut at a.
    task automatic model_cancel(input int a);
        ev_t nq[$];
        ev_t e;
        if (a >= last_done) return;
        foreach (q[i]) begin
            e = q[i];
            if (e.cyc > a) continue;
            if (!e.is_done && e.cyc + e.len - 1 > a) e.len = a - e.cyc + 1;
            nq.push_back(e);
        end
        q = nq;
        if (exp_hi > a) exp_hi = a;
        last_done = a;
    endtask

    task automatic step(input bit st, input bit ab, input bit rn, input int lv);
        bus.start = st;
        bus.abort = ab;
        resetn    = rn;
        bus.level = (ADDR_W + 1)'(lv);
        if (!rn || ab) model_cancel(cyc);
        if (st && rn && !ab) model_start(cyc, lv);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        resetn    = 1'b1;
        bus.level = (ADDR_W + 1)'($urandom_range(0, 31));
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step(1'b0, 1'b0, 1'b1, $urandom_range(0, 31));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_led"}, bus.led, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_sidx"}, bus.show_idx, 0);
    endtask

    task automatic close_run();
        ev_t e;
        chk("flash_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("flash_kind", e.is_done, 0);
            chk("flash_onset", run_on, e.cyc);
            chk("flash_len", run_len, e.len);
            chk("flash_led", run_led, 1 << e.color);
            chk("flash_addr", run_addr, e.addr);
            chk("flash_sidx", run_sidx, e.addr);
        end
        run_len = 0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            chk("busy", bus.busy, int'(cyc >= exp_lo && cyc <= exp_hi));
            if (!bus.busy && !bus.done) chk("idle_addr", bus.mem_addr, 0);
            if (run_len > 0 && bus.led != 4'(run_led)) close_run();
            if (bus.led != 4'b0000) begin
                if (run_len == 0) begin
                    run_led  = bus.led;
                    run_on   = cyc;
                    run_addr = bus.mem_addr;
                    run_sidx = bus.show_idx;
                end
                run_len++;
            end
            if (bus.done) begin
                chk("done_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("done_kind", e.is_done, 1);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s, lv, dur, ab_at;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.level = '0;
        for (int i = 0; i < MAX_LEN; i++) mem_q[i] = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        resetn = 1'b1;
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b1, 0);

        // single entry, colour 2
        mem_q[0] = 2'd2;
        s = cyc; step(1'b1, 1'b0, 1'b1, 1); run_to(s + 12);

        // three entries with a repeated colour
        mem_q[0] = 2'd0; mem_q[1] = 2'd3; mem_q[2] = 2'd3;
        s = cyc; step(1'b1, 1'b0, 1'b1, 3); run_to(s + 26);

        // clamp to MAX_LEN, then level 0
        for (int i = 0; i < MAX_LEN; i++) mem_q[i] = 2'($urandom_range(0, 3));
        s = cyc; step(1'b1, 1'b0, 1'b1, 20); run_to(s + MAX_LEN * PER + 4);
        s = cyc; step(1'b1, 1'b0, 1'b1, 0); run_to(s + 4);

        // abort in the ON phase of entry 1, then restart from entry 0
        s = cyc; step(1'b1, 1'b0, 1'b1, 3); run_to(s + 11);
        step(1'b0, 1'b1, 1'b1, 3);
        run_to(s + 14);
        s = cyc; step(1'b1, 1'b0, 1'b1, 3); run_to(s + 3 * PER + 3);

        // abort together with start while idle does nothing
        step(1'b1, 1'b1, 1'b1, 3); run_to(cyc + 5);

        // start re-pulsed while busy is ignored
        s = cyc; step(1'b1, 1'b0, 1'b1, 2);
        run_to(s + 3); step(1'b1, 1'b0, 1'b1, 5);
        run_to(s + 8); step(1'b1, 1'b0, 1'b1, 7);
        run_to(s + 2 * PER + 4);

        // reset during the OFF gap of entry 0
        s = cyc; step(1'b1, 1'b0, 1'b1, 2); run_to(s + 6);
        step(1'b0, 1'b0, 1'b0, 2);
        chk_quiet("midreset");
        run_to(s + 12);

        // randomized runs with stray starts and occasional abort
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < MAX_LEN; i++) mem_q[i] = 2'($urandom_range(0, 3));
            lv  = $urandom_range(0, 20);
            dur = ((lv > MAX_LEN) ? MAX_LEN : lv) * PER + 2;
            s   = cyc;
            step(1'b1, 1'b0, 1'b1, lv);
            ab_at = (r % 3 == 0) ? s + 1 + $urandom_range(0, dur) : -1;
            while (cyc < s + dur + 2)
                step($urandom_range(0, 9) == 0, cyc == ab_at, 1'b1, $urandom_range(0, 31));
            run_to(last_done + 3);
        end

        run_to(cyc + 3);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
